fp32_to_int32_conv: RTL and testbench

//  Multi-cycle IEEE-754 binary32 -> signed int32 converter, round-toward-zero (C cast semantics).

---
 rtl/fp_pkg.sv | 24 ++
 rtl/fp32_classify.sv | 29 ++
 rtl/fp32_to_int32_conv.sv | 167 ++++++++++++++++
 tb/tb_fp32_to_int32_conv.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FPU types and constants
package fp_pkg;

  localparam int FP32_EXP_W  = 8;
  localparam int FP32_FRAC_W = 23;
  localparam int FP32_BIAS   = 127;

  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIX   = 2'd2,
    OUT   = 2'd3
  } conv_state_t;

endpackage

// File: rtl/fp32_classify.sv
// rtl/fp32_classify.sv - combinational binary32 operand classifier
module fp32_classify
  import fp_pkg::*;
(
  input  fp32_t              i_op,
  output logic               o_is_zero,
  output logic               o_is_denorm,
  output logic               o_is_inf,
  output logic               o_is_nan,
  output logic signed [8:0]  o_unb_exp,
  output logic [23:0]        o_mant
);

  logic w_exp_zero;
  logic w_exp_ones;
  logic w_frac_zero;

  assign w_exp_zero  = (i_op.exp == '0);
  assign w_exp_ones  = (i_op.exp == '1);
  assign w_frac_zero = (i_op.frac == '0);

  assign o_is_zero   = w_exp_zero & w_frac_zero;
  assign o_is_denorm = w_exp_zero & ~w_frac_zero;
  assign o_is_inf    = w_exp_ones & w_frac_zero;
  assign o_is_nan    = w_exp_ones & ~w_frac_zero;
  assign o_unb_exp   = $signed({1'b0, i_op.exp}) - 9'(FP32_BIAS);
  assign o_mant      = {~w_exp_zero, i_op.frac};

endmodule

// File: rtl/fp32_to_int32_conv.sv
// rtl/fp32_to_int32_conv.sv - multi-cycle fp32 to int32 converter, truncating
// Alignment uses an iterative shifter moving at most SHIFT_STEP bits per cycle.
module fp32_to_int32_conv
  import fp_pkg::*;
#(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_invalid,
  output logic        out_inexact
);

  localparam logic [7:0]  STEP      = 8'(SHIFT_STEP);
  localparam logic [31:0] NEG_2P31  = 32'hCF00_0000;

  fp32_t              w_op;
  logic               w_is_zero, w_is_denorm, w_is_inf, w_is_nan;
  logic signed [8:0]  w_unb_exp;
  logic [23:0]        w_mant;

  assign w_op = fp32_t'(in_data);

  fp32_classify u_classify (
    .i_op        (w_op),
    .o_is_zero   (w_is_zero),
    .o_is_denorm (w_is_denorm),
    .o_is_inf    (w_is_inf),
    .o_is_nan    (w_is_nan),
    .o_unb_exp   (w_unb_exp),
    .o_mant      (w_mant)
  );

  conv_state_t r_state, w_next;
  logic [31:0] r_mag;
  logic        r_sticky;
  logic [7:0]  r_rem;
  logic        r_left;
  logic        r_sign;
  logic [31:0] r_out_data;
  logic        r_out_invalid;
  logic        r_out_inexact;

  logic        w_accept;
  logic        w_special;
  logic [31:0] w_spec_data;
  logic        w_spec_inv;
  logic        w_spec_inx;
  logic [31:0] w_sat;
  logic        w_left;
  logic [7:0]  w_n;
  logic [7:0]  w_amt;
  logic [31:0] w_lost;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == OUT);
  assign out_data    = r_out_data;
  assign out_invalid = r_out_invalid;
  assign out_inexact = r_out_inexact;

  assign w_accept = in_valid & in_ready;
  assign w_sat    = w_op.sign ? INT32_MIN : INT32_MAX;

  // Shift distance is |e - 23| = |exp - 150|; only meaningful on the normal path.
  assign w_left = (w_op.exp > 8'd150);
  assign w_n    = w_left ? (w_op.exp - 8'd150) : (8'd150 - w_op.exp);

  assign w_amt  = (r_rem > STEP) ? STEP : r_rem;
  assign w_lost = r_mag & ~(32'hFFFF_FFFF << w_amt);

  always_comb begin
    w_special   = 1'b1;
    w_spec_data = 32'h0;
    w_spec_inv  = 1'b0;
    w_spec_inx  = 1'b0;
    if (w_is_nan) begin
      w_spec_data = INT32_MAX;
      w_spec_inv  = 1'b1;
    end else if (w_is_inf) begin
      w_spec_data = w_sat;
      w_spec_inv  = 1'b1;
    end else if (in_data == NEG_2P31) begin
      w_spec_data = INT32_MIN;
    end else if (w_unb_exp >= 9'sd31) begin
      w_spec_data = w_sat;
      w_spec_inv  = 1'b1;
    end else if (w_is_zero || w_is_denorm || (w_unb_exp < 9'sd0)) begin
      w_spec_inx  = ~w_is_zero;
    end else begin
      w_special   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_special)        w_next = OUT;
          else if (w_n == 8'd0) w_next = FIX;
          else                  w_next = SHIFT;
        end
      end
      SHIFT:   if (r_rem == w_amt) w_next = FIX;
      FIX:     w_next = OUT;
      OUT:     if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag         <= 32'h0;
      r_sticky      <= 1'b0;
      r_rem         <= 8'h0;
      r_left        <= 1'b0;
      r_sign        <= 1'b0;
      r_out_data    <= 32'h0;
      r_out_invalid <= 1'b0;
      r_out_inexact <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sign   <= w_op.sign;
            r_mag    <= {8'h0, w_mant};
            r_sticky <= 1'b0;
            r_rem    <= w_n;
            r_left   <= w_left;
            if (w_special) begin
              r_out_data    <= w_spec_data;
              r_out_invalid <= w_spec_inv;
              r_out_inexact <= w_spec_inx;
            end
          end
        end
        SHIFT: begin
          if (r_left) begin
            r_mag <= r_mag << w_amt;
          end else begin
            r_mag    <= r_mag >> w_amt;
            r_sticky <= r_sticky | (|w_lost);
          end
          r_rem <= r_rem - w_amt;
        end
        FIX: begin
          r_out_data    <= r_sign ? (32'h0 - r_mag) : r_mag;
          r_out_invalid <= 1'b0;
          r_out_inexact <= r_sticky;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_to_int32_conv.sv
// tb/tb_fp32_to_int32_conv.sv - scoreboard bench for fp32_to_int32_conv
module tb_fp32_to_int32_conv;

  typedef struct {
    logic [31:0] d;
    logic        inv;
    logic        inx;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] in;
    logic [31:0] d;
    logic        inv;
    logic        inx;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
  logic [31:0] a_in_data = 32'h0, a_out_data;
  logic        a_out_invalid, a_out_inexact;
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
  logic [31:0] b_in_data = 32'h0, b_out_data;
  logic        b_out_invalid, b_out_inexact;

  exp_t qa[$];
  exp_t qb[$];
  exp_t cur_a, cur_b;
  bit   act_a = 0, act_b = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fp32_to_int32_conv #(.SHIFT_STEP(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_invalid(a_out_invalid), .out_inexact(a_out_inexact)
  );

  fp32_to_int32_conv #(.SHIFT_STEP(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_invalid(b_out_invalid), .out_inexact(b_out_inexact)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=event (t=%0t)", name, $time);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      act_a = 0;
    end else if (a_out_valid) begin
      if (!act_a) begin
        if (qa.size() == 0) begin
          fail_now("a_unexpected_output");
        end else begin
          cur_a = qa.pop_front();
          act_a = 1;
          chk("a_latency", 32'(cyc - cur_a.acc), 32'(cur_a.lat));
        end
      end
      if (act_a) begin
        chk("a_data", a_out_data, cur_a.d);
        chk("a_invalid", {31'h0, a_out_invalid}, {31'h0, cur_a.inv});
        chk("a_inexact", {31'h0, a_out_inexact}, {31'h0, cur_a.inx});
        chk("a_in_ready_busy", {31'h0, a_in_ready}, 32'h0);
        if (a_out_ready) act_a = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      act_b = 0;
    end else if (b_out_valid) begin
      if (!act_b) begin
        if (qb.size() == 0) begin
          fail_now("b_unexpected_output");
        end else begin
          cur_b = qb.pop_front();
          act_b = 1;
          chk("b_latency", 32'(cyc - cur_b.acc), 32'(cur_b.lat));
        end
      end
      if (act_b) begin
        chk("b_data", b_out_data, cur_b.d);
        chk("b_invalid", {31'h0, b_out_invalid}, {31'h0, cur_b.inv});
        chk("b_inexact", {31'h0, b_out_inexact}, {31'h0, cur_b.inx});
        if (b_out_ready) act_b = 0;
      end
    end
  end

  task automatic op(input bit sel, input vec_t v);
    exp_t e;
    int   guard;
    guard = 0;
    @(posedge clk); #1;
    while (!(sel ? b_in_ready : a_in_ready) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) fail_now("in_ready_wait");
    e.d   = v.d;
    e.inv = v.inv;
    e.inx = v.inx;
    e.lat = v.lat;
    e.acc = cyc;
    if (sel) begin
      qb.push_back(e);
      b_in_valid = 1'b1;
      b_in_data  = v.in;
    end else begin
      qa.push_back(e);
      a_in_valid = 1'b1;
      a_in_data  = v.in;
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    a_in_data  = 32'hDEAD_BEEF;
    b_in_data  = 32'hDEAD_BEEF;
  endtask

  task automatic wait_done(input bit sel);
    int guard;
    guard = 0;
    @(negedge clk);
    while (guard < 200 &&
           !(sel ? (qb.size() == 0 && !b_out_valid && b_in_ready)
                 : (qa.size() == 0 && !a_out_valid && a_in_ready))) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) fail_now(sel ? "b_done_wait" : "a_done_wait");
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    int   guard;

    vecs.push_back('{32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 8});
    vecs.push_back('{32'hC049_0FDB, 32'hFFFF_FFFD, 1'b0, 1'b1, 8});
    vecs.push_back('{32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0, 2});
    vecs.push_back('{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 4});
    vecs.push_back('{32'hCE80_0000, 32'hC000_0000, 1'b0, 1'b0, 4});
    vecs.push_back('{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1});
    vecs.push_back('{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1});
    vecs.push_back('{32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0, 1});
    vecs.push_back('{32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1});
    vecs.push_back('{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1});
    vecs.push_back('{32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 1});
    vecs.push_back('{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1});
    vecs.push_back('{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1});

    #3;
    chk("rst_in_ready", {31'h0, a_in_ready}, 32'h1);
    chk("rst_out_valid", {31'h0, a_out_valid}, 32'h0);
    chk("rst_out_data", a_out_data, 32'h0);
    chk("rst_flags", {30'h0, a_out_invalid, a_out_inexact}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      op(1'b0, vecs[i]);
      wait_done(1'b0);
    end

    // Backpressure: result must hold while out_ready is low, busy input ignored.
    a_out_ready = 1'b0;
    op(1'b0, '{32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0, 2});
    guard = 0;
    while (!a_out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) fail_now("stall_valid_wait");
    repeat (10) begin
      @(posedge clk); #1;
      a_in_valid = 1'b1;
      a_in_data  = 32'h3F80_0000;
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", {31'h0, a_out_valid}, 32'h0);
    chk("release_in_ready", {31'h0, a_in_ready}, 32'h1);
    @(posedge clk); #1;
    chk("idle_hold_data", a_out_data, 32'h0080_0000);
    wait_done(1'b0);

    // Reset mid-SHIFT aborts the operation.
    op(1'b0, '{32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 8});
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'h0, a_out_valid}, 32'h0);
    chk("abort_in_ready", {31'h0, a_in_ready}, 32'h1);
    chk("abort_out_data", a_out_data, 32'h0);
    qa.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    v = '{32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 8};
    op(1'b0, v);
    wait_done(1'b0);

    v.lat = 25;
    op(1'b1, v);
    wait_done(1'b1);
    op(1'b1, '{32'hC049_0FDB, 32'hFFFF_FFFD, 1'b0, 1'b1, 24});
    wait_done(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
